uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving FIFO depth 2**DEPTH_LOG2 entries.
REQ-002 SHALL have parameter TOUT_TICKS, default 640, giving the character-timeout length in RXCLK pulses (4 chars x 10 bits x 16).
REQ-003 SHALL have ports:
  CLK       in   1  clock
  RST       in   1  reset; asynchronous, active-high
  RXCLK     in   1  16x-baud enable pulse, one CLK wide
  FIFOEN    in   1  1 = FIFO mode; 0 = single holding register
  FIFOCLR   in   1  clear-FIFO strobe
  TRIG      in   2  trigger level: 00=1, 01=4, 10=8, 11=14 entries
  RXFINISHED in  1  receiver word-complete pulse
  DIN       in   8  received data
  PEI/FEI/BII in 1 each  parity, framing and break flags from the receiver
  RD        in   1  RBR read strobe, one CLK wide
  LSRRD     in   1  LSR read strobe, one CLK wide
  DOUT      out  8  head-entry data
  PE/FE/BI  out  1 each  head-entry flags, 0 when empty
  DR        out  1  data ready (level > 0)
  OE        out  1  overrun error, sticky
  ERRSUM    out  1  at least one stored entry has a PE, FE or BI flag set
  TRIGINT   out  1  level >= trigger (FIFO mode only)
  TOINT     out  1  character timeout
  RXCLEAR   out  1  receiver state reset pulse
  LEVEL     out  DEPTH_LOG2+1  entry count

Function
REQ-004 SHALL store entries as 11 bits {BII,FEI,PEI,DIN} in a circular buffer with read/write pointers that wrap modulo depth.
REQ-005 SHALL push on a RXFINISHED pulse when not full; the entry appears on DOUT the cycle after the push if the buffer was empty.
REQ-006 Push while full (FIFO mode) SHALL discard the word, set OE, and leave pointers and LEVEL unchanged.
REQ-007 With FIFOEN=0, effective depth SHALL be 1: a push while LEVEL=1 overwrites the entry and sets OE.
REQ-008 RD while LEVEL>0 SHALL pop one entry; RD while empty SHALL be ignored with no underflow.
REQ-009 Simultaneous RD and push SHALL pop then push; LEVEL is unchanged, no OE even when full, and the data is not lost.
REQ-010 OE SHALL clear on LSRRD, except that an overrun in the same cycle wins and OE stays 1.
REQ-011 ERRSUM SHALL be driven by an error-entry counter:
  - increments on pushing a flagged entry
  - decrements on popping a flagged entry
  - nets zero when both happen in the same cycle
  - on a non-FIFO overwrite, tracks the overwriting entry.
REQ-012 TRIGINT SHALL equal FIFOEN AND (LEVEL >= trigger count), combinationally.
REQ-013 The timeout counter SHALL:
  - reset to 0 on push, on RD, or when LEVEL=0
  - otherwise increment on each RXCLK, saturating at TOUT_TICKS.
REQ-014 TOINT SHALL be 1 while FIFOEN=1, LEVEL>0 and the counter equals TOUT_TICKS; it drops the cycle after RD or push.
REQ-015 FIFOCLR=1, or any change of FIFOEN (sampled against its registered previous value), SHALL:
  - empty the buffer in the next cycle: pointers, LEVEL, error counter and timeout counter go to 0
  - pulse RXCLEAR for exactly one cycle
  - leave OE unchanged.
REQ-016 A push coinciding with a clear SHALL be dropped.
REQ-017 All state SHALL be registered; outputs other than TRIGINT, DR and the head-entry fields SHALL come from flops.

Reset
REQ-018 On RST SHALL set to 0: pointers, LEVEL, counters, OE, TOINT, RXCLEAR and the registered FIFOEN copy; hence DR=0, TRIGINT=0, PE=FE=BI=0, ERRSUM=0.
REQ-019 DOUT SHALL read 0 after reset; buffer RAM contents need not be reset.
REQ-020 RST asserted mid-operation SHALL take effect immediately, and the first push after release SHALL be stored at entry 0.

Verification
REQ-021 Bench SHALL cover:
  - FIFOEN=1, TRIG=01, push 0x41,0x42,0x43,0x44 -> TRIGINT=1 at LEVEL=4; four RDs return 0x41..0x44 in order; DR=0 afterwards.
  - FIFOEN=1, DEPTH_LOG2=4, 17 pushes, no reads -> LEVEL=16, OE=1, 17th word absent; LSRRD -> OE=0.
  - FIFOEN=0, push 0x11 then 0x22 -> DOUT=0x22, OE=1, LEVEL=1.
  - Push 0x00 with BII=1,FEI=1 -> BI=FE=1 at head, ERRSUM=1; RD -> ERRSUM=0.
  - One entry held, 640 RXCLK pulses -> TOINT=1; RD -> TOINT=0 next cycle.
  - LEVEL=16 with RD and push in the same cycle -> LEVEL=16, OE=0; FIFOCLR -> LEVEL=0, one-cycle RXCLEAR.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-side buffer for a 16550-style UART: FIFO or single holding register,
// with overrun, error summary, trigger level and character-timeout reporting.
module uart_rx_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TOUT_TICKS = 640
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RXCLK,
    input  logic                  FIFOEN,
    input  logic                  FIFOCLR,
    input  logic [1:0]            TRIG,
    input  logic                  RXFINISHED,
    input  logic [7:0]            DIN,
    input  logic                  PEI,
    input  logic                  FEI,
    input  logic                  BII,
    input  logic                  RD,
    input  logic                  LSRRD,
    output logic [7:0]            DOUT,
    output logic                  PE,
    output logic                  FE,
    output logic                  BI,
    output logic                  DR,
    output logic                  OE,
    output logic                  ERRSUM,
    output logic                  TRIGINT,
    output logic                  TOINT,
    output logic                  RXCLEAR,
    output logic [DEPTH_LOG2:0]   LEVEL
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TOUT_TICKS + 1);

    logic [10:0]   mem [DEPTH];
    logic [10:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, wr_addr;
    logic [LW-1:0] level_next, err_cnt, err_cnt_next;
    logic [TW-1:0] tout_cnt, tout_cnt_next;
    logic          fifoen_q, oe_next, toint_next;
    logic          clr, full, not_empty, pop, push_adv, overwrite, overrun, do_write;
    logic          in_flag, head_flag;
    int unsigned   trig_count;

    assign head      = mem[rd_ptr];
    assign not_empty = (LEVEL != '0);
    assign in_flag   = BII | FEI | PEI;
    assign head_flag = |head[10:8];

    assign DR      = not_empty;
    assign DOUT    = not_empty ? head[7:0] : 8'h00;
    assign PE      = not_empty & head[8];
    assign FE      = not_empty & head[9];
    assign BI      = not_empty & head[10];
    assign TRIGINT = FIFOEN && (32'(LEVEL) >= trig_count);

    always_comb begin
        case (TRIG)
            2'b00:   trig_count = 1;
            2'b01:   trig_count = 4;
            2'b10:   trig_count = 8;
            default: trig_count = 14;
        endcase
    end

    // A mode change is treated exactly like an explicit clear strobe.
    assign clr       = FIFOCLR || (FIFOEN != fifoen_q);
    assign full      = FIFOEN ? (LEVEL == LW'(DEPTH)) : not_empty;
    assign pop       = RD && not_empty && !clr;
    assign push_adv  = RXFINISHED && !clr && (!full || pop);
    assign overrun   = RXFINISHED && !clr && full && !pop;
    assign overwrite = overrun && !FIFOEN;
    assign do_write  = push_adv || overwrite;
    assign wr_addr   = overwrite ? rd_ptr : wr_ptr;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        rd_ptr_next   = rd_ptr;
        wr_ptr_next   = wr_ptr;
        level_next    = LEVEL;
        err_cnt_next  = err_cnt;
        tout_cnt_next = tout_cnt;
        if (clr) begin
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            level_next    = '0;
            err_cnt_next  = '0;
            tout_cnt_next = '0;
        end else begin
            if (pop)      rd_ptr_next = rd_ptr + AW'(1);
            if (push_adv) wr_ptr_next = wr_ptr + AW'(1);
            level_next = LEVEL + LW'(push_adv) - LW'(pop);
            if (overwrite)
                err_cnt_next = LW'(in_flag);
            else
                err_cnt_next = err_cnt + LW'(push_adv && in_flag) - LW'(pop && head_flag);
            if (RXFINISHED || RD || !not_empty)
                tout_cnt_next = '0;
            else if (RXCLK && tout_cnt != TW'(TOUT_TICKS))
                tout_cnt_next = tout_cnt + TW'(1);
        end
        oe_next    = overrun ? 1'b1 : (LSRRD ? 1'b0 : OE);
        toint_next = FIFOEN && (level_next != '0) && (tout_cnt_next == TW'(TOUT_TICKS));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            LEVEL    <= '0;
            err_cnt  <= '0;
            tout_cnt <= '0;
            OE       <= 1'b0;
            ERRSUM   <= 1'b0;
            TOINT    <= 1'b0;
            RXCLEAR  <= 1'b0;
            fifoen_q <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            LEVEL    <= level_next;
            err_cnt  <= err_cnt_next;
            tout_cnt <= tout_cnt_next;
            OE       <= oe_next;
            ERRSUM   <= (err_cnt_next != '0);
            TOINT    <= toint_next;
            RXCLEAR  <= clr;
            fifoen_q <= FIFOEN;
        end
    end

    // NOTE: the storage array has no reset; empty-state outputs are masked by LEVEL instead.
    always_ff @(posedge CLK) begin
        if (do_write) mem[wr_addr] <= {BII, FEI, PEI, DIN};
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_uart_rx_ctrl;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int TOUT       = 640;

    logic       CLK = 0, RST = 0, RXCLK = 0, FIFOEN = 0, FIFOCLR = 0;
    logic [1:0] TRIG = 0;
    logic       RXFINISHED = 0, PEI = 0, FEI = 0, BII = 0, RD = 0, LSRRD = 0;
    logic [7:0] DIN = 0;
    logic [7:0] DOUT;
    logic       PE, FE, BI, DR, OE, ERRSUM, TRIGINT, TOINT, RXCLEAR;
    logic [DEPTH_LOG2:0] LEVEL;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .TOUT_TICKS(TOUT)) dut (
        .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .FIFOEN(FIFOEN), .FIFOCLR(FIFOCLR),
        .TRIG(TRIG), .RXFINISHED(RXFINISHED), .DIN(DIN), .PEI(PEI), .FEI(FEI),
        .BII(BII), .RD(RD), .LSRRD(LSRRD), .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
        .DR(DR), .OE(OE), .ERRSUM(ERRSUM), .TRIGINT(TRIGINT), .TOINT(TOINT),
        .RXCLEAR(RXCLEAR), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    // Reference model: the buffer is a plain queue, everything else derived from it.
    logic [10:0] mq[$];
    bit          m_oe, m_fen, m_rxclear, m_toint;
    int          m_tout;

    task automatic model_reset();
        mq.delete();
        m_oe = 0; m_fen = 0; m_rxclear = 0; m_toint = 0; m_tout = 0;
    endtask

    task automatic model_step();
        bit          clr, ovr;
        int          cap, pre;
        logic [10:0] w;
        if (RST) begin
            model_reset();
            return;
        end
        pre = mq.size();
        ovr = 0;
        clr = FIFOCLR || (FIFOEN != m_fen);
        m_fen = FIFOEN;
        m_rxclear = clr;
        w = {BII, FEI, PEI, DIN};
        if (clr) begin
            mq.delete();
            m_tout = 0;
            if (LSRRD) m_oe = 0;
        end else begin
            cap = FIFOEN ? DEPTH : 1;
            if (RD && mq.size() > 0) void'(mq.pop_front());
            if (RXFINISHED) begin
                if (mq.size() < cap) mq.push_back(w);
                else begin
                    ovr = 1;
                    if (!FIFOEN) mq[0] = w;
                end
            end
            if (ovr) m_oe = 1;
            else if (LSRRD) m_oe = 0;
            if (RXFINISHED || RD || pre == 0) m_tout = 0;
            else if (RXCLK && m_tout < TOUT) m_tout++;
        end
        m_toint = FIFOEN && mq.size() > 0 && m_tout == TOUT;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input logic [2:0] flags);
        DIN = d; {BII, FEI, PEI} = flags; RXFINISHED = 1;
        tick();
        RXFINISHED = 0; {BII, FEI, PEI} = 3'b000;
    endtask

    task automatic read_word();
        RD = 1;
        tick();
        RD = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        model_reset();
        tick();
        RST = 0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        FIFOEN = 0;
        RST = 1;
        model_reset();
        #3;
        vectors++; if (LEVEL !== 0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", LEVEL); end
        vectors++; if ({DR, OE, ERRSUM, TRIGINT, TOINT, RXCLEAR} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 000000", {DR, OE, ERRSUM, TRIGINT, TOINT, RXCLEAR}); end
        vectors++; if ({DOUT, PE, FE, BI} !== 11'h0) begin miscompares++; $display("FAIL reset_head: got %h want 0", {DOUT, PE, FE, BI}); end
        tick();
        RST = 0;
        tick();
    endtask

    task automatic test_trigger();
        FIFOEN = 1; TRIG = 2'b01;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            push_word(8'h41 + 8'(i), 3'b000);
            vectors++; if (TRIGINT !== (i == 3)) begin miscompares++; $display("FAIL trig_level%0d: got %b want %b", i + 1, TRIGINT, i == 3); end
        end
        vectors++; if (LEVEL !== 4) begin miscompares++; $display("FAIL trig_count: got %0d want 4", LEVEL); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (DOUT !== 8'h41 + 8'(i)) begin miscompares++; $display("FAIL trig_order%0d: got %h want %h", i, DOUT, 8'h41 + 8'(i)); end
            read_word();
        end
        vectors++; if (DR !== 0) begin miscompares++; $display("FAIL trig_drained: got DR=%b want 0", DR); end
    endtask

    task automatic test_overrun();
        FIFOCLR = 1; tick(); FIFOCLR = 0; tick();
        for (int i = 0; i < 17; i++) push_word(8'(i + 1), 3'b000);
        vectors++; if (LEVEL !== 16) begin miscompares++; $display("FAIL ovr_level: got %0d want 16", LEVEL); end
        vectors++; if (OE !== 1) begin miscompares++; $display("FAIL ovr_oe_set: got %b want 1", OE); end
        LSRRD = 1; tick(); LSRRD = 0;
        vectors++; if (OE !== 0) begin miscompares++; $display("FAIL ovr_oe_clear: got %b want 0", OE); end
        for (int i = 0; i < 16; i++) begin
            vectors++; if (DOUT !== 8'(i + 1)) begin miscompares++; $display("FAIL ovr_data%0d: got %h want %h", i, DOUT, 8'(i + 1)); end
            read_word();
        end
        vectors++; if (LEVEL !== 0) begin miscompares++; $display("FAIL ovr_17th_absent: got level %0d want 0", LEVEL); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push_word(8'hA0 + 8'(i), 3'b000);
        DIN = 8'hEE; RXFINISHED = 1; RD = 1;
        tick();
        RXFINISHED = 0; RD = 0;
        vectors++; if (LEVEL !== 16) begin miscompares++; $display("FAIL b2b_level: got %0d want 16", LEVEL); end
        vectors++; if (OE !== 0) begin miscompares++; $display("FAIL b2b_oe: got %b want 0", OE); end
        vectors++; if (DOUT !== 8'hA1) begin miscompares++; $display("FAIL b2b_head: got %h want a1", DOUT); end
        FIFOCLR = 1; tick(); FIFOCLR = 0;
        vectors++; if (LEVEL !== 0 || RXCLEAR !== 1) begin miscompares++; $display("FAIL clr_apply: got level %0d rxclear %b want 0/1", LEVEL, RXCLEAR); end
        tick();
        vectors++; if (RXCLEAR !== 0) begin miscompares++; $display("FAIL clr_pulse_width: got %b want 0", RXCLEAR); end
    endtask

    task automatic test_single();
        FIFOEN = 0; tick(); tick();
        push_word(8'h11, 3'b000);
        push_word(8'h22, 3'b000);
        vectors++; if (DOUT !== 8'h22) begin miscompares++; $display("FAIL single_dout: got %h want 22", DOUT); end
        vectors++; if (OE !== 1) begin miscompares++; $display("FAIL single_oe: got %b want 1", OE); end
        vectors++; if (LEVEL !== 1) begin miscompares++; $display("FAIL single_level: got %0d want 1", LEVEL); end
        LSRRD = 1; tick(); LSRRD = 0;
    endtask

    task automatic test_error_flags();
        FIFOEN = 1; tick(); tick();
        push_word(8'h00, 3'b110);
        vectors++; if ({BI, FE, PE} !== 3'b110) begin miscompares++; $display("FAIL err_head_flags: got %b want 110", {BI, FE, PE}); end
        vectors++; if (ERRSUM !== 1) begin miscompares++; $display("FAIL err_sum_set: got %b want 1", ERRSUM); end
        read_word();
        vectors++; if (ERRSUM !== 0 || BI !== 0) begin miscompares++; $display("FAIL err_sum_clear: got errsum %b bi %b want 0/0", ERRSUM, BI); end
    endtask

    task automatic test_timeout();
        push_word(8'h33, 3'b000);
        RXCLK = 1;
        repeat (TOUT - 1) tick();
        vectors++; if (TOINT !== 0) begin miscompares++; $display("FAIL tout_early: got %b want 0", TOINT); end
        tick();
        vectors++; if (TOINT !== 1) begin miscompares++; $display("FAIL tout_fire: got %b want 1", TOINT); end
        read_word();
        RXCLK = 0;
        vectors++; if (TOINT !== 0) begin miscompares++; $display("FAIL tout_drop: got %b want 0", TOINT); end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i), 3'b000);
        #2 RST = 1;
        #1;
        vectors++; if (LEVEL !== 0 || DR !== 0) begin miscompares++; $display("FAIL midrst_async: got level %0d dr %b want 0/0", LEVEL, DR); end
        tick();
        RST = 0;
        tick(); tick();
        push_word(8'h5A, 3'b000);
        vectors++; if (DOUT !== 8'h5A || LEVEL !== 1) begin miscompares++; $display("FAIL midrst_first_push: got %h/%0d want 5a/1", DOUT, LEVEL); end
    endtask

    task automatic test_random();
        int          trig_tab [4] = '{1, 4, 8, 14};
        logic [7:0]  e_dout;
        logic [2:0]  e_flags;
        bit          e_err;
        FIFOEN = 1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 2) FIFOEN = ~FIFOEN;
            FIFOCLR    = ($urandom_range(99) < 2);
            TRIG       = 2'($urandom_range(3));
            RXFINISHED = ($urandom_range(99) < 45);
            RD         = ($urandom_range(99) < 30);
            LSRRD      = ($urandom_range(99) < 10);
            RXCLK      = $urandom_range(1);
            DIN        = 8'($urandom);
            {BII, FEI, PEI} = ($urandom_range(99) < 25) ? 3'($urandom) : 3'b000;
            tick();
            e_dout  = mq.size() > 0 ? mq[0][7:0] : 8'h00;
            e_flags = mq.size() > 0 ? mq[0][10:8] : 3'b000;
            e_err   = 0;
            foreach (mq[k]) if (mq[k][10:8] != 3'b000) e_err = 1;
            vectors++; if (LEVEL !== mq.size()) begin miscompares++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, LEVEL, mq.size()); end
            vectors++; if (DOUT !== e_dout) begin miscompares++; $display("FAIL rnd_dout@%0d: got %h want %h", n, DOUT, e_dout); end
            vectors++; if ({BI, FE, PE} !== e_flags) begin miscompares++; $display("FAIL rnd_flags@%0d: got %b want %b", n, {BI, FE, PE}, e_flags); end
            vectors++; if (DR !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_dr@%0d: got %b", n, DR); end
            vectors++; if (OE !== m_oe) begin miscompares++; $display("FAIL rnd_oe@%0d: got %b want %b", n, OE, m_oe); end
            vectors++; if (ERRSUM !== e_err) begin miscompares++; $display("FAIL rnd_errsum@%0d: got %b want %b", n, ERRSUM, e_err); end
            vectors++; if (TRIGINT !== (FIFOEN && mq.size() >= trig_tab[TRIG])) begin miscompares++; $display("FAIL rnd_trigint@%0d: got %b", n, TRIGINT); end
            vectors++; if (TOINT !== m_toint) begin miscompares++; $display("FAIL rnd_toint@%0d: got %b want %b", n, TOINT, m_toint); end
            vectors++; if (RXCLEAR !== m_rxclear) begin miscompares++; $display("FAIL rnd_rxclear@%0d: got %b want %b", n, RXCLEAR, m_rxclear); end
        end
        {FIFOCLR, RXFINISHED, RD, LSRRD, RXCLK} = 5'b0;
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_overrun();
        test_back_to_back();
        test_single();
        test_error_flags();
        test_timeout();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
